arc4_engine: RTL and testbench
==============================

# arc4_engine

Parametrised ARC4 decryption engine, the successor to the fixed 24-bit-key task3 datapath. It runs three phases on one accepted key: S-array initialisation, key scheduling (KSA) and keystream generation (PRGA). It decrypts a length-prefixed ciphertext memory into a plaintext memory and reports whether the result is printable ASCII. The block sits between the top-level key source (switches or the cracking scanner) and three external single-port synchronous RAMs (S, CT, PT).

## Interface
Parameters:
- KEY_BYTES, 3, key length in bytes; legal range 1..32.

Ports:
- clk  in  1  system clock; all logic rises on posedge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  start request; sampled only while rdy=1.
- rdy  out  1  engine idle and able to accept en.
- key  in  8*KEY_BYTES  key; byte 0 = key[8*KEY_BYTES-1 -: 8] (big-endian); latched on accept.
- key_valid  out  1  result flag; meaningful while rdy=1 after a run.
- s_addr  out  8  S RAM address.
- s_rddata  in  8  S RAM read data.
- s_wrdata  out  8  S RAM write data.
- s_wren  out  1  S RAM write enable.
- ct_addr  out  8  CT RAM address.
- ct_rddata  in  8  CT RAM read data.
- pt_addr  out  8  PT RAM address.
- pt_wrdata  out  8  PT RAM write data.
- pt_wren  out  1  PT RAM write enable.

## Operation
- States: IDLE, INIT, KSA, PRGA_LEN, PRGA, DONE.
- IDLE: rdy=1. On en=1, latch key, clear key_valid, and go to INIT. rdy=0 from the next cycle.
- INIT: write S[i]=i for i=0..255, one write per cycle.
- KSA:
  - j=0.
  - For i=0..255: j = (j + S[i] + key[i mod KEY_BYTES]) mod 256, then swap S[i] and S[j].
  - i mod KEY_BYTES uses a wrapping counter, not a divider.
- PRGA_LEN: read ct[0] = L, and write pt[0]=L.
- PRGA:
  - i=j=0.
  - For k=1..L: i=i+1, j=j+S[i], swap S[i] and S[j], pad = S[(S[i]+S[j]) mod 256], pt[k] = pad ^ ct[k].
- All index arithmetic is 8-bit and wraps modulo 256.
- DONE: key_valid is set per Configuration, rdy=1 the following cycle, and the FSM returns to IDLE.
- en while rdy=0 is ignored. en held high keeps starting new runs back-to-back, each from INIT.
- L=0: pt[0]=0 is written, no PRGA iterations run, and key_valid=1.
- Never assert s_wren and read back the same address in the same cycle. At most one write per RAM per cycle.

## Timing
- RAM read latency is 1 cycle: data for the address presented in cycle t is valid on rddata in cycle t+1.
- Reset values: rdy=1, key_valid=0, every address/wrdata=0, s_wren=0, pt_wren=0. The FSM resets to IDLE.
- rst mid-run: next cycle is IDLE with rdy=1 and both wrens 0. S/PT contents are undefined, and the next run re-executes INIT.
- Cycle budget, measured from the accepting edge to rdy=1 (upper bounds; the bench timeout is their sum):
  - INIT: 256 cycles.
  - KSA: ≤6 cycles per iteration.
  - PRGA_LEN: ≤3 cycles.
  - PRGA: ≤10 cycles per byte.
  - DONE: ≤2 cycles.
- key_valid changes only on the cycle rdy rises, or on accept (cleared).

## Configuration
- ARC4_VALID_CHECK_EN defined:
  - Each pt[k], k≥1, is checked before its write.
  - A byte outside 0x20..0x7E is not written. key_valid=0, and the FSM jumps to DONE (early abort).
  - If all bytes pass, key_valid=1.
- ARC4_VALID_CHECK_EN undefined: no check, all L bytes are written, and key_valid=1 at every normal completion.

## Structure
- Package arc4_pkg holds:
  - the state enum;
  - ASCII_LO=8'h20 and ASCII_HI=8'h7E;
  - S_SIZE=256;
  - the per-phase cycle bounds (shared with the bench).
- Sub-module arc4_ksa owns INIT+KSA and the S port during those phases. It has its own en/rdy pair, key input and KEY_BYTES parameter.
- The top owns PRGA, muxes the S port, and drives CT/PT.

## Test plan
- KEY_BYTES=3, key=24'h4B6579 ("Key"), CT = 09 BB F3 16 E8 D9 40 AF 0A D3 -> PT = 09 50 6C 61 69 6E 74 65 78 74 ("Plaintext"), key_valid=1, rdy within budget.
- KEY_BYTES=4, key=32'h57696B69 ("Wiki"), CT = 05 10 21 BF 04 20 -> PT = 05 70 65 64 69 61 ("pedia"), key_valid=1.
- Invalid key, with ARC4_VALID_CHECK_EN: KEY_BYTES=3, key=24'h4B6578 on the "Plaintext" CT -> key_valid=0, fewer than 10 pt_wren pulses, and every written pt[k], k≥1, lies in 20..7E.
- Empty message: CT = 00 -> exactly one pt_wren at address 0 with data 00, then key_valid=1.
- Reset mid-run: rst for 1 cycle during KSA (about 500 cycles after accept) -> next cycle rdy=1, s_wren=0, pt_wren=0. Re-issue en with "Key" -> correct "Plaintext" result.
- Handshake: pulse en while rdy=0 during PRGA -> ignored, and the result is identical to a single run. Exactly one accept per rdy=1 cycle.

Source files
------------

// File: rtl/arc4_pkg.sv
// ARC4 engine shared definitions.
// Holds the top-level phase enum, the printable-ASCII window, the S-array size and the
// per-phase cycle bounds. The bounds are upper limits that the testbench also uses as its
// timeout.
package arc4_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StKsa,
    StPrgaLen,
    StPrga,
    StDone
  } arc4_state_e;

  localparam logic [7:0] ASCII_LO = 8'h20;
  localparam logic [7:0] ASCII_HI = 8'h7E;

  localparam int unsigned S_SIZE = 256;

  localparam int unsigned INIT_CYCLES          = 256;
  localparam int unsigned KSA_CYCLES_PER_ITER  = 6;
  localparam int unsigned PRGA_LEN_CYCLES      = 3;
  localparam int unsigned PRGA_CYCLES_PER_BYTE = 10;
  localparam int unsigned DONE_CYCLES          = 2;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= ASCII_LO) && (b <= ASCII_HI);
  endfunction

  // Worst-case cycles from the accepting edge to rdy=1 for a message of len bytes.
  function automatic int unsigned run_budget(input int unsigned len);
    return INIT_CYCLES + KSA_CYCLES_PER_ITER * S_SIZE + PRGA_LEN_CYCLES +
           PRGA_CYCLES_PER_BYTE * len + DONE_CYCLES;
  endfunction

endpackage

// File: rtl/arc4_ksa.sv
// ARC4 S-array initialisation and key scheduling.
// Owns the S RAM port while busy: first writes S[i]=i for every i, then runs the key
// schedule with a read-i / read-j / write-i / write-j sequence (4 cycles per i).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en_i, rdy_o   start request (taken only while rdy_o=1) / idle flag
//   key_i         key, byte 0 in the top byte; latched on accept
//   init_busy_o   high while the S[i]=i fill is running
//   s_addr_o, s_wrdata_o, s_wren_o, s_rddata_i   S RAM port (1-cycle read latency)
module arc4_ksa
  import arc4_pkg::*;
#(
  parameter int unsigned KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic [8*KEY_BYTES-1:0] key_i,
  output logic                   rdy_o,
  output logic                   init_busy_o,
  output logic [7:0]             s_addr_o,
  output logic [7:0]             s_wrdata_o,
  output logic                   s_wren_o,
  input  logic [7:0]             s_rddata_i
);

  localparam int unsigned KW      = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [7:0]  LastIdx = 8'(S_SIZE - 1);

  localparam logic [2:0] KsaIdle  = 3'd0;
  localparam logic [2:0] KsaInit  = 3'd1;
  localparam logic [2:0] KsaRdI   = 3'd2;
  localparam logic [2:0] KsaCalc  = 3'd3;
  localparam logic [2:0] KsaSwapI = 3'd4;
  localparam logic [2:0] KsaSwapJ = 3'd5;

  logic [2:0]             state_q, state_d;
  logic [7:0]             i_q, i_d;
  logic [7:0]             j_q, j_d;
  logic [7:0]             si_q, si_d;
  logic [KW-1:0]          kidx_q, kidx_d;
  logic [8*KEY_BYTES-1:0] key_q, key_d;
  logic [8*KEY_BYTES-1:0] key_sh;
  logic [7:0]             key_byte;

  // Key byte kidx sits kidx bytes below the top; shift it up rather than divide.
  always_comb begin
    key_sh   = key_q << {kidx_q, 3'b000};
    key_byte = key_sh[8*KEY_BYTES-1 -: 8];
  end

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    si_d       = si_q;
    kidx_d     = kidx_q;
    key_d      = key_q;
    s_addr_o   = '0;
    s_wrdata_o = '0;
    s_wren_o   = 1'b0;
    unique case (state_q)
      KsaIdle: begin
        if (en_i) begin
          key_d   = key_i;
          i_d     = '0;
          state_d = KsaInit;
        end
      end
      KsaInit: begin
        s_addr_o   = i_q;
        s_wrdata_o = i_q;
        s_wren_o   = 1'b1;
        i_d        = i_q + 8'd1;
        if (i_q == LastIdx) begin
          j_d     = '0;
          kidx_d  = '0;
          state_d = KsaRdI;
        end
      end
      KsaRdI: begin
        s_addr_o = i_q;
        state_d  = KsaCalc;
      end
      KsaCalc: begin
        // s_rddata_i holds S[i]; fetch S[j] at the new j.
        si_d     = s_rddata_i;
        j_d      = j_q + s_rddata_i + key_byte;
        s_addr_o = j_d;
        state_d  = KsaSwapI;
      end
      KsaSwapI: begin
        s_addr_o   = i_q;
        s_wrdata_o = s_rddata_i;
        s_wren_o   = 1'b1;
        state_d    = KsaSwapJ;
      end
      KsaSwapJ: begin
        s_addr_o   = j_q;
        s_wrdata_o = si_q;
        s_wren_o   = 1'b1;
        i_d        = i_q + 8'd1;
        kidx_d     = (kidx_q == KW'(KEY_BYTES - 1)) ? '0 : kidx_q + 1'b1;
        state_d    = (i_q == LastIdx) ? KsaIdle : KsaRdI;
      end
      default: state_d = KsaIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= KsaIdle;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      kidx_q  <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      kidx_q  <= kidx_d;
      key_q   <= key_d;
    end
  end

  assign rdy_o       = (state_q == KsaIdle);
  assign init_busy_o = (state_q == KsaInit);

endmodule

// File: rtl/arc4_engine.sv
// ARC4 decryption engine: S init + key schedule (in arc4_ksa), then keystream generation
// over a length-prefixed ciphertext RAM, writing the plaintext RAM and a key_valid flag.
// Optional feature macro: ARC4_VALID_CHECK_EN -- when defined, each plaintext byte is
// checked against the printable ASCII range before it is written; the first failing byte
// is dropped and the run ends early with key_valid=0.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en, rdy         start request (taken only while rdy=1) / idle flag
//   key             key, byte 0 = top byte; latched on accept
//   key_valid       result flag, updated when rdy rises, cleared on accept
//   s_*             S RAM port (read latency 1)
//   ct_addr/rddata  ciphertext RAM read port, ct[0] = message length
//   pt_*            plaintext RAM write port
module arc4_engine
  import arc4_pkg::*;
#(
  parameter int unsigned KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic                   key_valid,
  output logic [7:0]             s_addr,
  input  logic [7:0]             s_rddata,
  output logic [7:0]             s_wrdata,
  output logic                   s_wren,
  output logic [7:0]             ct_addr,
  input  logic [7:0]             ct_rddata,
  output logic [7:0]             pt_addr,
  output logic [7:0]             pt_wrdata,
  output logic                   pt_wren
);

  // Sub-steps of one PRGA byte.
  localparam logic [2:0] PrgRdI   = 3'd0;
  localparam logic [2:0] PrgRdJ   = 3'd1;
  localparam logic [2:0] PrgSwapI = 3'd2;
  localparam logic [2:0] PrgSwapJ = 3'd3;
  localparam logic [2:0] PrgRdPad = 3'd4;
  localparam logic [2:0] PrgOut   = 3'd5;

  arc4_state_e state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [7:0]  i_q, i_d, j_q, j_d, k_q, k_d, len_q, len_d;
  logic [7:0]  si_q, si_d, sj_q, sj_d, ct_q, ct_d;
  logic        ok_q, ok_d;
  logic        key_valid_q, key_valid_d;
  logic [7:0]  pt_byte;

  logic        ksa_en, ksa_rdy, ksa_init;
  logic [7:0]  ksa_s_addr, ksa_s_wrdata;
  logic        ksa_s_wren;
  logic [7:0]  prga_s_addr, prga_s_wrdata;
  logic        prga_s_wren;

  arc4_ksa #(
    .KEY_BYTES (KEY_BYTES)
  ) u_ksa (
    .clk         (clk),
    .rst         (rst),
    .en_i        (ksa_en),
    .key_i       (key),
    .rdy_o       (ksa_rdy),
    .init_busy_o (ksa_init),
    .s_addr_o    (ksa_s_addr),
    .s_wrdata_o  (ksa_s_wrdata),
    .s_wren_o    (ksa_s_wren),
    .s_rddata_i  (s_rddata)
  );

  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    i_d           = i_q;
    j_d           = j_q;
    k_d           = k_q;
    len_d         = len_q;
    si_d          = si_q;
    sj_d          = sj_q;
    ct_d          = ct_q;
    ok_d          = ok_q;
    key_valid_d   = key_valid_q;
    ksa_en        = 1'b0;
    prga_s_addr   = '0;
    prga_s_wrdata = '0;
    prga_s_wren   = 1'b0;
    ct_addr       = '0;
    pt_addr       = '0;
    pt_wrdata     = '0;
    pt_wren       = 1'b0;
    pt_byte       = '0;
    unique case (state_q)
      StIdle: begin
        if (en) begin
          ksa_en      = 1'b1;
          key_valid_d = 1'b0;
          state_d     = StInit;
        end
      end
      StInit: begin
        if (!ksa_init) state_d = StKsa;
      end
      StKsa: begin
        if (ksa_rdy) begin
          step_d  = '0;
          state_d = StPrgaLen;
        end
      end
      StPrgaLen: begin
        if (step_q == '0) begin
          ct_addr = '0;
          step_d  = 3'd1;
        end else begin
          pt_wren   = 1'b1;
          pt_wrdata = ct_rddata;
          len_d     = ct_rddata;
          k_d       = 8'd1;
          i_d       = '0;
          j_d       = '0;
          ok_d      = 1'b1;
          step_d    = PrgRdI;
          state_d   = (ct_rddata == 8'd0) ? StDone : StPrga;
        end
      end
      StPrga: begin
        unique case (step_q)
          PrgRdI: begin
            i_d         = i_q + 8'd1;
            prga_s_addr = i_d;
            ct_addr     = k_q;
            step_d      = PrgRdJ;
          end
          PrgRdJ: begin
            si_d        = s_rddata;
            ct_d        = ct_rddata;
            j_d         = j_q + s_rddata;
            prga_s_addr = j_d;
            step_d      = PrgSwapI;
          end
          PrgSwapI: begin
            sj_d          = s_rddata;
            prga_s_addr   = i_q;
            prga_s_wrdata = s_rddata;
            prga_s_wren   = 1'b1;
            step_d        = PrgSwapJ;
          end
          PrgSwapJ: begin
            prga_s_addr   = j_q;
            prga_s_wrdata = si_q;
            prga_s_wren   = 1'b1;
            step_d        = PrgRdPad;
          end
          PrgRdPad: begin
            // Post-swap S[i]+S[j] equals the pre-swap sum, so the held copies suffice.
            prga_s_addr = si_q + sj_q;
            step_d      = PrgOut;
          end
          PrgOut: begin
            pt_byte = s_rddata ^ ct_q;
`ifdef ARC4_VALID_CHECK_EN
            if (!is_printable(pt_byte)) begin
              ok_d    = 1'b0;
              state_d = StDone;
            end else
`endif
            begin
              pt_wren   = 1'b1;
              pt_addr   = k_q;
              pt_wrdata = pt_byte;
              if (k_q == len_q) begin
                state_d = StDone;
              end else begin
                k_d    = k_q + 8'd1;
                step_d = PrgRdI;
              end
            end
          end
          default: step_d = PrgRdI;
        endcase
      end
      StDone: begin
        key_valid_d = ok_q;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // The KSA block drives the S port only during INIT/KSA; it is idle (all zero) otherwise.
  always_comb begin
    if (state_q == StInit || state_q == StKsa) begin
      s_addr   = ksa_s_addr;
      s_wrdata = ksa_s_wrdata;
      s_wren   = ksa_s_wren;
    end else begin
      s_addr   = prga_s_addr;
      s_wrdata = prga_s_wrdata;
      s_wren   = prga_s_wren;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      step_q      <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      len_q       <= '0;
      si_q        <= '0;
      sj_q        <= '0;
      ct_q        <= '0;
      ok_q        <= 1'b0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      len_q       <= len_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      ct_q        <= ct_d;
      ok_q        <= ok_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign rdy       = (state_q == StIdle);
  assign key_valid = key_valid_q;

endmodule

// File: tb/tb_arc4_engine.sv
// Testbench for arc4_engine: one 3-byte-key instance (a_*) and one 4-byte-key instance
// (b_*), each with its own S/CT/PT RAM models, checked against a plain RC4 reference.
module tb_arc4_engine;
  import arc4_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests_run;
  int tests_failed;

  logic        a_en, a_rdy, a_key_valid, a_s_wren, a_pt_wren, a_clr;
  logic [23:0] a_key;
  logic [7:0]  a_s_addr, a_s_rd, a_s_wrdata, a_ct_addr, a_ct_rd, a_pt_addr, a_pt_wrdata;
  logic [7:0]  a_s [256];
  logic [7:0]  a_ct[256];
  logic [7:0]  a_pt[256];
  int          a_cnt;

  logic        b_en, b_rdy, b_key_valid, b_s_wren, b_pt_wren, b_clr;
  logic [31:0] b_key;
  logic [7:0]  b_s_addr, b_s_rd, b_s_wrdata, b_ct_addr, b_ct_rd, b_pt_addr, b_pt_wrdata;
  logic [7:0]  b_s [256];
  logic [7:0]  b_ct[256];
  logic [7:0]  b_pt[256];
  int          b_cnt;

  arc4_engine #(.KEY_BYTES(3)) dut_a (
    .clk(clk), .rst(rst), .en(a_en), .rdy(a_rdy), .key(a_key), .key_valid(a_key_valid),
    .s_addr(a_s_addr), .s_rddata(a_s_rd), .s_wrdata(a_s_wrdata), .s_wren(a_s_wren),
    .ct_addr(a_ct_addr), .ct_rddata(a_ct_rd),
    .pt_addr(a_pt_addr), .pt_wrdata(a_pt_wrdata), .pt_wren(a_pt_wren)
  );

  arc4_engine #(.KEY_BYTES(4)) dut_b (
    .clk(clk), .rst(rst), .en(b_en), .rdy(b_rdy), .key(b_key), .key_valid(b_key_valid),
    .s_addr(b_s_addr), .s_rddata(b_s_rd), .s_wrdata(b_s_wrdata), .s_wren(b_s_wren),
    .ct_addr(b_ct_addr), .ct_rddata(b_ct_rd),
    .pt_addr(b_pt_addr), .pt_wrdata(b_pt_wrdata), .pt_wren(b_pt_wren)
  );

  // Synchronous single-port RAMs, 1-cycle read latency; PT can be poisoned to 8'hEE.
  always @(posedge clk) begin
    if (a_s_wren) a_s[a_s_addr] <= a_s_wrdata;
    a_s_rd  <= a_s[a_s_addr];
    a_ct_rd <= a_ct[a_ct_addr];
    if (a_clr) begin
      for (int n = 0; n < 256; n++) a_pt[n] <= 8'hEE;
      a_cnt <= 0;
    end else if (a_pt_wren) begin
      a_pt[a_pt_addr] <= a_pt_wrdata;
      a_cnt <= a_cnt + 1;
    end
  end

  always @(posedge clk) begin
    if (b_s_wren) b_s[b_s_addr] <= b_s_wrdata;
    b_s_rd  <= b_s[b_s_addr];
    b_ct_rd <= b_ct[b_ct_addr];
    if (b_clr) begin
      for (int n = 0; n < 256; n++) b_pt[n] <= 8'hEE;
      b_cnt <= 0;
    end else if (b_pt_wren) begin
      b_pt[b_pt_addr] <= b_pt_wrdata;
      b_cnt <= b_cnt + 1;
    end
  end

  function automatic logic rdy_of(input int sel);
    return (sel == 0) ? a_rdy : b_rdy;
  endfunction
  function automatic logic kv_of(input int sel);
    return (sel == 0) ? a_key_valid : b_key_valid;
  endfunction
  function automatic int cnt_of(input int sel);
    return (sel == 0) ? a_cnt : b_cnt;
  endfunction
  function automatic logic [7:0] pt_of(input int sel, input int idx);
    return (sel == 0) ? a_pt[idx] : b_pt[idx];
  endfunction

  // Reference RC4: returns the bytes expected at pt[0..] in write order and the flag.
  function automatic void rc4_model(input logic [31:0] key, input int nbytes,
                                    input logic [7:0] ct[$],
                                    output logic [7:0] pt[$], output logic ok);
    logic [7:0] s[256];
    logic [7:0] kb[$];
    logic [7:0] t;
    int i, j;
    for (int n = nbytes - 1; n >= 0; n--) kb.push_back(key[8*n +: 8]);
    for (int n = 0; n < 256; n++) s[n] = n[7:0];
    j = 0;
    for (int n = 0; n < 256; n++) begin
      j = (j + s[n] + kb[n % nbytes]) % 256;
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    pt = {};
    pt.push_back(ct[0]);
    ok = 1'b1;
    i = 0;
    j = 0;
    for (int k = 1; k <= int'(ct[0]); k++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      t = s[(s[i] + s[j]) % 256] ^ ct[k];
`ifdef ARC4_VALID_CHECK_EN
      if (t < 8'h20 || t > 8'h7E) begin
        ok = 1'b0;
        break;
      end
`endif
      pt.push_back(t);
    end
  endfunction

  task automatic start_run(input int sel, input logic [31:0] key, input logic [7:0] ct[$],
                           input bit hold);
    @(negedge clk);
    for (int n = 0; n < ct.size(); n++) begin
      if (sel == 0) a_ct[n] = ct[n];
      else b_ct[n] = ct[n];
    end
    if (sel == 0) a_clr = 1'b1;
    else b_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    b_clr = 1'b0;
    a_key = key[23:0];
    b_key = key;
    if (sel == 0) a_en = 1'b1;
    else b_en = 1'b1;
    @(negedge clk);
    if (!hold) begin
      a_en = 1'b0;
      b_en = 1'b0;
    end
  endtask

  // Waits (bounded) for rdy and snapshots the PT RAM; resets the DUTs if the bound expires.
  task automatic finish_run(input int sel, input int len, output logic [7:0] got[$],
                            output int nwr, output logic kv, output logic done);
    int cyc;
    cyc = 1;
    while (!rdy_of(sel) && cyc < int'(run_budget(len))) begin
      @(negedge clk);
      cyc++;
    end
    done = rdy_of(sel);
    got = {};
    for (int n = 0; n <= len; n++) got.push_back(pt_of(sel, n));
    nwr = cnt_of(sel);
    kv  = kv_of(sel);
    if (!done) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst  = 1'b1;
    a_en = 1'b0; b_en = 1'b0; a_clr = 1'b0; b_clr = 1'b0;
    a_key = '0; b_key = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({a_rdy, a_key_valid, a_s_wren, a_pt_wren} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL reset_flags_a: got %b expected 1000",
               {a_rdy, a_key_valid, a_s_wren, a_pt_wren});
    end
    tests_run++;
    if ({a_s_addr, a_s_wrdata, a_ct_addr, a_pt_addr, a_pt_wrdata} !== 40'h0) begin
      tests_failed++;
      $display("FAIL reset_buses_a: got %h expected 0",
               {a_s_addr, a_s_wrdata, a_ct_addr, a_pt_addr, a_pt_wrdata});
    end
    tests_run++;
    if ({b_rdy, b_key_valid, b_s_wren, b_pt_wren} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL reset_flags_b: got %b expected 1000",
               {b_rdy, b_key_valid, b_s_wren, b_pt_wren});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_vector_key;
    logic [7:0] ct[$], exp[$], got[$];
    int nwr;
    logic kv, done;
    ct  = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    exp = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    start_run(0, 32'h004B6579, ct, 1'b0);
    finish_run(0, 9, got, nwr, kv, done);
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++; $display("FAIL key_budget: rdy=%b expected 1 within budget", done);
    end
    tests_run++;
    if (kv !== 1'b1) begin tests_failed++; $display("FAIL key_valid: got %b expected 1", kv); end
    tests_run++;
    if (nwr != 10) begin tests_failed++; $display("FAIL key_nwr: got %0d expected 10", nwr); end
    for (int n = 0; n < 10; n++) begin
      tests_run++;
      if (got[n] !== exp[n]) begin
        tests_failed++;
        $display("FAIL key_pt[%0d]: got %02h expected %02h", n, got[n], exp[n]);
      end
    end
  endtask

  task automatic test_vector_wiki;
    logic [7:0] ct[$], exp[$], got[$];
    int nwr;
    logic kv, done;
    ct  = '{8'h05, 8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
    exp = '{8'h05, 8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
    start_run(1, 32'h57696B69, ct, 1'b0);
    finish_run(1, 5, got, nwr, kv, done);
    tests_run++;
    if (done !== 1'b1 || kv !== 1'b1 || nwr != 6) begin
      tests_failed++;
      $display("FAIL wiki_status: done=%b kv=%b nwr=%0d expected 1 1 6", done, kv, nwr);
    end
    for (int n = 0; n < 6; n++) begin
      tests_run++;
      if (got[n] !== exp[n]) begin
        tests_failed++;
        $display("FAIL wiki_pt[%0d]: got %02h expected %02h", n, got[n], exp[n]);
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] ct[$], exp[$], got[$];
    logic [31:0] key;
    int nwr, len, sel;
    logic kv, ok, done;
    for (int it = 0; it < 8; it++) begin
      sel = it % 2;
      key = $urandom;
      if (sel == 0) key[31:24] = 8'h00;
      len = $urandom_range(0, 24);
      ct  = {};
      ct.push_back(8'(len));
      for (int n = 0; n < len; n++) ct.push_back(8'($urandom));
      rc4_model(key, (sel == 0) ? 3 : 4, ct, exp, ok);
      start_run(sel, key, ct, 1'b0);
      finish_run(sel, len, got, nwr, kv, done);
      tests_run++;
      if (done !== 1'b1 || kv !== ok || nwr != exp.size()) begin
        tests_failed++;
        $display("FAIL rand%0d_status: done=%b kv=%b nwr=%0d expected 1 %b %0d",
                 it, done, kv, nwr, ok, exp.size());
      end
      for (int n = 0; n < exp.size(); n++) begin
        tests_run++;
        if (got[n] !== exp[n]) begin
          tests_failed++;
          $display("FAIL rand%0d_pt[%0d]: got %02h expected %02h", it, n, got[n], exp[n]);
        end
      end
    end
  endtask

  task automatic test_empty;
    logic [7:0] ct[$], got[$];
    int nwr;
    logic kv, done;
    ct = '{8'h00};
    start_run(0, 32'h004B6579, ct, 1'b0);
    finish_run(0, 0, got, nwr, kv, done);
    tests_run++;
    if (done !== 1'b1 || nwr != 1 || got[0] !== 8'h00 || kv !== 1'b1) begin
      tests_failed++;
      $display("FAIL empty: done=%b nwr=%0d pt0=%02h kv=%b expected 1 1 00 1",
               done, nwr, got[0], kv);
    end
  endtask

  task automatic test_invalid_key;
    logic [7:0] ct[$], exp[$], got[$];
    int nwr;
    logic kv, ok, done;
    ct = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    rc4_model(32'h004B6578, 3, ct, exp, ok);
    start_run(0, 32'h004B6578, ct, 1'b0);
    finish_run(0, 9, got, nwr, kv, done);
    tests_run++;
    if (done !== 1'b1 || kv !== ok || nwr != exp.size()) begin
      tests_failed++;
      $display("FAIL badkey_status: done=%b kv=%b nwr=%0d expected 1 %b %0d",
               done, kv, nwr, ok, exp.size());
    end
    for (int n = 0; n < exp.size(); n++) begin
      tests_run++;
      if (got[n] !== exp[n]) begin
        tests_failed++;
        $display("FAIL badkey_pt[%0d]: got %02h expected %02h", n, got[n], exp[n]);
      end
    end
`ifdef ARC4_VALID_CHECK_EN
    tests_run++;
    if (kv !== 1'b0 || nwr >= 10) begin
      tests_failed++;
      $display("FAIL badkey_abort: kv=%b nwr=%0d expected 0 and <10", kv, nwr);
    end
    for (int n = 1; n < nwr && n < 10; n++) begin
      tests_run++;
      if (got[n] < 8'h20 || got[n] > 8'h7E) begin
        tests_failed++;
        $display("FAIL badkey_ascii[%0d]: got %02h expected 20..7E", n, got[n]);
      end
    end
`endif
  endtask

  task automatic test_reset_midrun;
    logic [7:0] ct[$], exp[$], got[$];
    int nwr;
    logic kv, ok, done;
    ct = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    start_run(0, 32'h004B6579, ct, 1'b0);
    repeat (500) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if ({a_rdy, a_s_wren, a_pt_wren} !== 3'b100) begin
      tests_failed++;
      $display("FAIL midrst_state: rdy/s_wren/pt_wren got %b expected 100",
               {a_rdy, a_s_wren, a_pt_wren});
    end
    rc4_model(32'h004B6579, 3, ct, exp, ok);
    start_run(0, 32'h004B6579, ct, 1'b0);
    finish_run(0, 9, got, nwr, kv, done);
    tests_run++;
    if (done !== 1'b1 || kv !== ok || nwr != exp.size()) begin
      tests_failed++;
      $display("FAIL midrst_rerun: done=%b kv=%b nwr=%0d expected 1 %b %0d",
               done, kv, nwr, ok, exp.size());
    end
    for (int n = 0; n < exp.size(); n++) begin
      tests_run++;
      if (got[n] !== exp[n]) begin
        tests_failed++;
        $display("FAIL midrst_pt[%0d]: got %02h expected %02h", n, got[n], exp[n]);
      end
    end
  endtask

  task automatic test_handshake;
    logic [7:0] ct[$], exp[$], got[$];
    int nwr, cyc;
    logic kv, ok, done;
    ct = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    rc4_model(32'h004B6579, 3, ct, exp, ok);
    start_run(0, 32'h004B6579, ct, 1'b0);
    cyc = 0;
    while (a_cnt < 1 && cyc < int'(run_budget(9))) begin
      @(negedge clk);
      cyc++;
    end
    tests_run++;
    if (a_cnt < 1) begin
      tests_failed++;
      $display("FAIL hs_reach_prga: pt writes %0d expected >=1", a_cnt);
    end
    for (int n = 0; n < 3; n++) begin
      a_en = 1'b1;
      tests_run++;
      if (a_rdy !== 1'b0) begin
        tests_failed++;
        $display("FAIL hs_busy[%0d]: rdy got %b expected 0", n, a_rdy);
      end
      @(negedge clk);
    end
    a_en = 1'b0;
    finish_run(0, 9, got, nwr, kv, done);
    tests_run++;
    if (done !== 1'b1 || kv !== ok || nwr != exp.size()) begin
      tests_failed++;
      $display("FAIL hs_status: done=%b kv=%b nwr=%0d expected 1 %b %0d",
               done, kv, nwr, ok, exp.size());
    end
    for (int n = 0; n < exp.size(); n++) begin
      tests_run++;
      if (got[n] !== exp[n]) begin
        tests_failed++;
        $display("FAIL hs_pt[%0d]: got %02h expected %02h", n, got[n], exp[n]);
      end
    end
    // rdy must stay high with en low: nothing was queued by the ignored pulses.
    @(negedge clk);
    tests_run++;
    if (a_rdy !== 1'b1) begin
      tests_failed++;
      $display("FAIL hs_no_restart: rdy got %b expected 1", a_rdy);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] ct[$], exp[$], got[$];
    int nwr;
    logic kv, ok, done;
    ct = '{8'h05, 8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
    rc4_model(32'h57696B69, 4, ct, exp, ok);
    start_run(1, 32'h57696B69, ct, 1'b1);
    finish_run(1, 5, got, nwr, kv, done);
    tests_run++;
    if (done !== 1'b1 || kv !== ok) begin
      tests_failed++;
      $display("FAIL b2b_first: done=%b kv=%b expected 1 %b", done, kv, ok);
    end
    // en still high: the single rdy=1 cycle accepts a new run immediately.
    @(negedge clk);
    b_en = 1'b0;
    tests_run++;
    if ({b_rdy, b_key_valid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL b2b_accept: rdy/key_valid got %b expected 00", {b_rdy, b_key_valid});
    end
    finish_run(1, 5, got, nwr, kv, done);
    tests_run++;
    if (done !== 1'b1 || kv !== ok || nwr != 2 * exp.size()) begin
      tests_failed++;
      $display("FAIL b2b_second: done=%b kv=%b nwr=%0d expected 1 %b %0d",
               done, kv, nwr, ok, 2 * exp.size());
    end
    for (int n = 0; n < exp.size(); n++) begin
      tests_run++;
      if (got[n] !== exp[n]) begin
        tests_failed++;
        $display("FAIL b2b_pt[%0d]: got %02h expected %02h", n, got[n], exp[n]);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_vector_key();
    test_vector_wiki();
    test_empty();
    test_invalid_key();
    test_random();
    test_reset_midrun();
    test_handshake();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
